// File: rtl/wb_arbiter_pkg.sv
// Shared processor constants and the writeback source encoding used by the
// register-file write arbiter.
package wb_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MDU
  } wr_src_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Result queue for the multi-cycle unit. It exposes per-entry destination
// registers so decode can detect hazards against results that are still queued.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [REG_W-1:0]                 push_rd,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [REG_W-1:0]                 head_rd,
  output logic [DATA_W-1:0]                head_data,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_W-1:0]      entry_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0]                  rptr;
  logic [PW-1:0]                  wptr;
  logic [PW:0]                    count;
  logic [DEPTH-1:0][DATA_W-1:0]   mem_data;
  logic                           do_push;
  logic                           do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = entry_rd[rptr];
  assign head_data = mem_data[rptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) begin
        wptr              <= wptr + 1'b1;
        entry_valid[wptr] <= 1'b1;
      end
      if (do_pop) begin
        rptr              <= rptr + 1'b1;
        entry_valid[rptr] <= 1'b0;
      end
      if (do_push != do_pop) begin
        count <= do_push ? count + 1'b1 : count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wptr] <= push_data;
      entry_rd[wptr] <= push_rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the pipeline has priority, MDU results queue
// up behind it, and a starving queue head briefly stalls the pipeline.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  input  logic [REG_W-1:0]  mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  chk_rs,
  input  logic [REG_W-1:0]  chk_rt,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic              regWrite,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] writeData
);

  localparam int WAIT_W = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(STARVE_LIMIT - 1);

  logic                                q_full;
  logic                                q_empty;
  logic [REG_W-1:0]                    q_head_rd;
  logic [DATA_W-1:0]                   q_head_data;
  logic [FIFO_DEPTH-1:0]               q_valid;
  logic [FIFO_DEPTH-1:0][REG_W-1:0]    q_rd;
  logic                                push;
  logic                                pop;
  logic                                pipe_req;
  logic                                blocked;
  logic [WAIT_W-1:0]                   wait_cnt;
  wr_src_e                             sel;

  assign pipe_req  = pipe_valid && (pipe_rd != REG_ZERO);
  assign mdu_ready = !q_full;
  assign push      = mdu_valid && !q_full && (mdu_rd != REG_ZERO);
  assign pop       = (sel == SRC_MDU);
  assign blocked   = !pipe_stall && pipe_req && !q_empty;

  always_comb begin
    sel = SRC_NONE;
    if (pipe_stall) begin
      if (!q_empty) sel = SRC_MDU;
    end else if (pipe_req) begin
      sel = SRC_PIPE;
    end else if (!q_empty) begin
      sel = SRC_MDU;
    end
  end

  // The head stays visible for hazard checks during the cycle it is popped.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_valid[i] && (q_rd[i] == chk_rs) && (chk_rs != REG_ZERO)) hazard_rs = 1'b1;
      if (q_valid[i] && (q_rd[i] == chk_rt) && (chk_rt != REG_ZERO)) hazard_rt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite   <= 1'b0;
      rd         <= '0;
      writeData  <= '0;
      pipe_stall <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      regWrite <= (sel != SRC_NONE);
      case (sel)
        SRC_PIPE: begin
          rd        <= pipe_rd;
          writeData <= pipe_data;
        end
        SRC_MDU: begin
          rd        <= q_head_rd;
          writeData <= q_head_data;
        end
        default: ;
      endcase

      if (pop || q_empty) begin
        wait_cnt <= '0;
      end else if (blocked) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // Stall lasts exactly one cycle, during which the head is drained.
      if (pipe_stall) begin
        pipe_stall <= 1'b0;
      end else if (blocked && (wait_cnt >= WAIT_TRIP)) begin
        pipe_stall <= 1'b1;
      end
    end
  end

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (mdu_rd),
    .push_data  (mdu_data),
    .pop        (pop),
    .full       (q_full),
    .empty      (q_empty),
    .head_rd    (q_head_rd),
    .head_data  (q_head_data),
    .entry_valid(q_valid),
    .entry_rd   (q_rd)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic [4:0]  chk_rs = '0;
  logic [4:0]  chk_rt = '0;
  logic        pipe_stall, mdu_ready, hazard_rs, hazard_rt, regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
    .regWrite(regWrite), .rd(rd), .writeData(writeData)
  );

  // Reference model: a queue of pending MDU results and the expected outputs.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic        m_stall = 1'b0;
  int          m_wait = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_we = 1'b0; m_rd = '0; m_data = '0; m_stall = 1'b0; m_wait = 0;
    end else begin
      automatic bit preq     = pipe_valid && (pipe_rd != 5'd0);
      automatic bit was_full = (q.size() >= DEPTH);
      automatic bit had      = (q.size() > 0);
      automatic bit blocked  = !m_stall && preq && had;
      automatic bit popped   = 1'b0;
      ent_t head;
      m_we = 1'b0;
      if ((m_stall || !preq) && had) begin
        head = q.pop_front();
        m_we = 1'b1; m_rd = head.rd; m_data = head.data; popped = 1'b1;
      end else if (!m_stall && preq) begin
        m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
      end
      if (popped || !had) m_wait = 0;
      else if (blocked) m_wait++;
      m_stall = blocked && (m_wait >= LIMIT);
      if (mdu_valid && !was_full && (mdu_rd != 5'd0)) q.push_back('{mdu_rd, mdu_data});
    end
  end

  function automatic bit haz(input logic [4:0] r);
    haz = 1'b0;
    if (r != 5'd0) foreach (q[i]) if (q[i].rd == r) haz = 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model.regWrite", regWrite, m_we);
      chk("model.rd", rd, m_rd);
      chk("model.writeData", writeData, m_data);
      chk("model.pipe_stall", pipe_stall, m_stall);
      chk("model.mdu_ready", mdu_ready, q.size() < DEPTH);
      chk("model.hazard_rs", hazard_rs, haz(chk_rs));
      chk("model.hazard_rt", hazard_rt, haz(chk_rt));
    end
  end

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".regWrite"}, regWrite, we);
    chk({tag, ".rd"}, rd, r);
    chk({tag, ".writeData"}, writeData, d);
  endtask

  initial begin
    // Initial reset, checked while still asserted.
    #1 rst = 1'b1;
    #1;
    expect_wr("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.pipe_stall", pipe_stall, 1'b0);
    chk("reset.mdu_ready", mdu_ready, 1'b1);
    tick(); tick();
    rst = 1'b0;

    // Pipeline wins over a simultaneous MDU result; MDU lands a cycle later.
    drive(1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd7, 32'h12345678);
    tick();
    expect_wr("prio1", 1'b1, 5'd5, 32'hAAAA0001);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_rs = 5'd7;
    #1 chk("prio.hazard_rs", hazard_rs, 1'b1);
    tick();
    expect_wr("prio2", 1'b1, 5'd7, 32'h12345678);
    chk_rs = 5'd0;
    tick();
    expect_wr("prio_idle", 1'b0, 5'd7, 32'h12345678);

    // Fill the queue behind a busy pipeline; third offer waits, order kept.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    tick();
    expect_wr("full_a", 1'b1, 5'd1, 32'h11);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    tick();
    expect_wr("full_b", 1'b1, 5'd2, 32'h22);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88);
    #1 chk("full.ready_busy", mdu_ready, 1'b0);
    tick();
    expect_wr("full_c", 1'b1, 5'd6, 32'h66);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    #1 chk("full.ready_pop", mdu_ready, 1'b0);
    tick();
    expect_wr("full_d", 1'b1, 5'd3, 32'h33);
    chk("full.ready_after_pop", mdu_ready, 1'b1);
    tick();
    expect_wr("full_e", 1'b1, 5'd4, 32'h44);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("full_f", 1'b1, 5'd8, 32'h88);
    tick();
    expect_wr("full_idle", 1'b0, 5'd8, 32'h88);

    // Starvation: three blocked cycles force a one-cycle pipeline stall.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    expect_wr("starve_push", 1'b0, 5'd8, 32'h88);
    drive(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve1", 1'b1, 5'd10, 32'hA0);
    chk("starve1.stall", pipe_stall, 1'b0);
    drive(1'b1, 5'd11, 32'hA1, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve2", 1'b1, 5'd11, 32'hA1);
    chk("starve2.stall", pipe_stall, 1'b0);
    drive(1'b1, 5'd12, 32'hA2, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve3", 1'b1, 5'd12, 32'hA2);
    chk("starve3.stall", pipe_stall, 1'b1);
    drive(1'b1, 5'd13, 32'hA3, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve_pop", 1'b1, 5'd9, 32'h99);
    chk("starve_pop.stall", pipe_stall, 1'b0);
    tick();
    expect_wr("starve_held", 1'b1, 5'd13, 32'hA3);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("starve_idle", 1'b0, 5'd13, 32'hA3);

    // Hazard visibility for a queued result, including its pop cycle.
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd12, 32'hC);
    tick();
    expect_wr("haz_a", 1'b1, 5'd20, 32'h20);
    drive(1'b1, 5'd21, 32'h21, 1'b0, 5'd0, 32'd0);
    chk_rs = 5'd12; chk_rt = 5'd0;
    #1;
    chk("haz.rs_queued", hazard_rs, 1'b1);
    chk("haz.rt_zero", hazard_rt, 1'b0);
    tick();
    expect_wr("haz_b", 1'b1, 5'd21, 32'h21);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk_rt = 5'd12;
    #1;
    chk("haz.rs_popping", hazard_rs, 1'b1);
    chk("haz.rt_popping", hazard_rt, 1'b1);
    tick();
    expect_wr("haz_c", 1'b1, 5'd12, 32'hC);
    chk("haz.rs_written", hazard_rs, 1'b0);
    chk_rs = 5'd0; chk_rt = 5'd0;

    // Register zero from either source is never written nor queued.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    tick();
    expect_wr("zero1", 1'b0, 5'd12, 32'hC);
    tick();
    expect_wr("zero2", 1'b0, 5'd12, 32'hC);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("zero3", 1'b0, 5'd12, 32'hC);

    // Reset with two results queued: nothing stale may ever be written.
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd14, 32'hE);
    tick();
    drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd15, 32'hF);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_mid.ready_full", mdu_ready, 1'b0);
    rst = 1'b1;
    #1;
    expect_wr("rst_mid", 1'b0, 5'd0, 32'd0);
    chk("rst_mid.stall", pipe_stall, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk_rs = 5'd14; chk_rt = 5'd15;
    #1;
    chk("rst_mid.ready_after", mdu_ready, 1'b1);
    chk("rst_mid.no_haz_rs", hazard_rs, 1'b0);
    chk("rst_mid.no_haz_rt", hazard_rt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid.no_stale_write", regWrite, 1'b0);
    end
    chk_rs = 5'd0; chk_rt = 5'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
